// File: rtl/board_input_ctrl.sv
// -----------------------------------------------------------------------------
// board_input_ctrl
//   Board-input end of the FPGA user interface. Each raw slide switch is
//   synchronised (2 flops), debounced and turned into rise/fall pulses. The
//   debounced levels drive the CPU run control: a reset-hold/run/pause FSM,
//   a slow tick that produces a one-cycle clock-enable for the core, a
//   heartbeat that toggles on every enable, and the display select fields.
//   Everything runs on one clock; the core is advanced with o_cpu_ce instead
//   of a gated or divided clock.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_sw_raw       asynchronous raw switch pins            [N_SW]
//   o_sw_db        debounced switch levels                 [N_SW]
//   o_sw_rise      1-cycle pulse on debounced 0->1         [N_SW]
//   o_sw_fall      1-cycle pulse on debounced 1->0         [N_SW]
//   o_cpu_rst      reset to the CPU core
//   o_cpu_ce       1-cycle clock-enable for the CPU core
//   o_run_state    2'b00 RESET_HOLD, 2'b01 RUN, 2'b10 PAUSE
//   o_disp_mode    debounced switches [3:2]
//   o_disp_addr    debounced switches [10:4]
//   o_heartbeat    toggles after every o_cpu_ce pulse
//
// Configuration macro
//   BOARD_INPUT_STEP_EN : when defined, a debounced rising edge on switch
//   STEP_BIT while paused issues exactly one o_cpu_ce (single step).
// -----------------------------------------------------------------------------
module board_input_ctrl #(
    parameter int N_SW            = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TICK_CYCLES     = 50000000,
    parameter int RST_HOLD        = 16,
    parameter int STEP_BIT        = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_SW-1:0] i_sw_raw,
    output logic [N_SW-1:0] o_sw_db,
    output logic [N_SW-1:0] o_sw_rise,
    output logic [N_SW-1:0] o_sw_fall,
    output logic            o_cpu_rst,
    output logic            o_cpu_ce,
    output logic [1:0]      o_run_state,
    output logic [1:0]      o_disp_mode,
    output logic [6:0]      o_disp_addr,
    output logic            o_heartbeat
);

    localparam int DB_CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TK_CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HD_CW = $clog2(RST_HOLD + 1);

    localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_CW-1:0] TK_LAST = TK_CW'(TICK_CYCLES - 1);
    localparam logic [HD_CW-1:0] HD_LOAD = HD_CW'(RST_HOLD);

`ifdef BOARD_INPUT_STEP_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'b00,
        ST_RUN        = 2'b01,
        ST_PAUSE      = 2'b10
    } state_t;

    logic [N_SW-1:0]  r_sync1;
    logic [N_SW-1:0]  r_sync2;
    logic [N_SW-1:0]  r_db;
    logic [N_SW-1:0]  r_rise;
    logic [N_SW-1:0]  r_fall;
    logic [DB_CW-1:0] r_db_cnt [N_SW];

    state_t           r_state;
    logic [HD_CW-1:0] r_hold;
    logic [TK_CW-1:0] r_tick;
    logic             r_ce;
    logic             r_hb;
    logic             r_cpu_rst;

    state_t           w_next_state;
    logic [HD_CW-1:0] w_next_hold;
    logic [TK_CW-1:0] w_next_tick;
    logic             w_next_ce;
    logic             w_next_hb;
    logic             w_step;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: count consecutive mismatch cycles, accept on the last one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_SW; i++) begin
                r_db_cnt[i] <= '0;
            end
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                if (r_sync2[i] != r_db[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        // Pulse is registered alongside the new level so both
                        // become visible in the same cycle.
                        r_db[i]     <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                        r_rise[i]   <= r_sync2[i];
                        r_fall[i]   <= ~r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_CW'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // Run FSM next state and reset-hold countdown; a reset request overrides all.
    always_comb begin
        w_next_state = r_state;
        w_next_hold  = r_hold;
        if (r_db[0]) begin
            w_next_state = ST_RESET_HOLD;
            w_next_hold  = HD_LOAD;
        end else begin
            case (r_state)
                ST_RESET_HOLD: begin
                    // Leave on the edge where the countdown reaches zero.
                    if (r_hold <= HD_CW'(1)) begin
                        w_next_hold  = '0;
                        w_next_state = r_db[1] ? ST_PAUSE : ST_RUN;
                    end else begin
                        w_next_hold  = r_hold - HD_CW'(1);
                    end
                end
                ST_RUN: begin
                    if (r_db[1]) begin
                        w_next_state = ST_PAUSE;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (!r_db[1]) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_PAUSE;
                    end
                end
                default: begin
                    w_next_state = ST_RESET_HOLD;
                    w_next_hold  = HD_LOAD;
                end
            endcase
        end
    end

    // Single-step request: only honoured while staying in PAUSE.
    always_comb begin
        w_step = STEP_EN && (r_state == ST_PAUSE) && (w_next_state == ST_PAUSE)
                 && r_rise[STEP_BIT];
    end

    // Tick counter, clock-enable and heartbeat next values.
    always_comb begin
        w_next_tick = r_tick;
        w_next_ce   = 1'b0;
        w_next_hb   = r_hb;
        if (w_next_state == ST_RESET_HOLD) begin
            // Heading into reset: suppress the enable so it never overlaps cpu_rst.
            w_next_tick = '0;
            w_next_ce   = 1'b0;
            w_next_hb   = 1'b0;
        end else begin
            if (r_ce) begin
                w_next_hb = ~r_hb;
            end else begin
                w_next_hb = r_hb;
            end
            if (r_state == ST_RUN) begin
                if (r_tick == TK_LAST) begin
                    w_next_tick = '0;
                    w_next_ce   = 1'b1;
                end else begin
                    w_next_tick = r_tick + TK_CW'(1);
                end
            end else if (r_state == ST_PAUSE) begin
                w_next_ce = w_step;
            end else begin
                w_next_tick = '0;
            end
        end
    end

    // Run-control state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_RESET_HOLD;
            r_hold    <= HD_LOAD;
            r_tick    <= '0;
            r_ce      <= 1'b0;
            r_hb      <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_hold    <= w_next_hold;
            r_tick    <= w_next_tick;
            r_ce      <= w_next_ce;
            r_hb      <= w_next_hb;
            r_cpu_rst <= (w_next_state == ST_RESET_HOLD);
        end
    end

    assign o_sw_db     = r_db;
    assign o_sw_rise   = r_rise;
    assign o_sw_fall   = r_fall;
    assign o_cpu_rst   = r_cpu_rst;
    assign o_cpu_ce    = r_ce;
    assign o_run_state = r_state;
    assign o_heartbeat = r_hb;
    assign o_disp_mode = r_db[3:2];
    assign o_disp_addr = r_db[10:4];

endmodule

// File: tb/tb_board_input_ctrl.sv
// Self-checking bench for board_input_ctrl with small timing parameters.
// A behavioural model (stability window per switch, mode/countdown/phase for
// the run control) predicts every output each cycle; directed checks pin the
// documented timelines.
module tb_board_input_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 10;
    localparam int HOLD = 3;

    localparam int M_RH    = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] raw;

    logic [15:0] sw_db, sw_rise, sw_fall;
    logic        cpu_rst, cpu_ce, heartbeat;
    logic [1:0]  run_state, disp_mode;
    logic [6:0]  disp_addr;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic [15:0] m_s1, m_s2, m_db, m_rise, m_fall;
    logic [15:0] m_win [DEB];
    int          m_mode, m_hold, m_phase;
    logic        m_ce, m_hb;

    always #5 clk = ~clk;

    board_input_ctrl #(
        .N_SW(16), .DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK),
        .RST_HOLD(HOLD), .STEP_BIT(15)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sw_raw(raw),
        .o_sw_db(sw_db), .o_sw_rise(sw_rise), .o_sw_fall(sw_fall),
        .o_cpu_rst(cpu_rst), .o_cpu_ce(cpu_ce), .o_run_state(run_state),
        .o_disp_mode(disp_mode), .o_disp_addr(disp_addr), .o_heartbeat(heartbeat)
    );

    function automatic logic [1:0] mode_code(input int m);
        if (m == M_RUN)        return 2'b01;
        else if (m == M_PAUSE) return 2'b10;
        else                   return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [15:0] db_b, rise_b;
        logic        ce_b, stable;
        db_b   = m_db;
        rise_b = m_rise;
        ce_b   = m_ce;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
            for (int j = 0; j < DEB; j++) m_win[j] = '0;
            m_mode = M_RH; m_hold = HOLD; m_phase = 0; m_ce = 1'b0; m_hb = 1'b0;
        end else begin
            // A switch changes once its synchronised value has differed from
            // the accepted level for DEB consecutive cycles.
            for (int j = 0; j < DEB - 1; j++) m_win[j] = m_win[j+1];
            m_win[DEB-1] = m_s2;
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < 16; b++) begin
                stable = 1'b1;
                for (int j = 0; j < DEB; j++) if (m_win[j][b] == db_b[b]) stable = 1'b0;
                if (stable) begin
                    m_db[b] = ~db_b[b];
                    if (m_db[b]) m_rise[b] = 1'b1;
                    else         m_fall[b] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            if (db_b[0]) begin
                m_mode = M_RH; m_hold = HOLD; m_phase = 0; m_ce = 1'b0; m_hb = 1'b0;
            end else begin
                m_hb = m_hb ^ ce_b;
                m_ce = 1'b0;
                if (m_mode == M_RH) begin
                    m_hold  = m_hold - 1;
                    m_phase = 0;
                    if (m_hold == 0) m_mode = db_b[1] ? M_PAUSE : M_RUN;
                end else if (m_mode == M_RUN) begin
                    m_phase = (m_phase + 1) % TICK;
                    m_ce    = (m_phase == 0);
                    if (db_b[1]) m_mode = M_PAUSE;
                end else begin
`ifdef BOARD_INPUT_STEP_EN
                    m_ce = db_b[1] && rise_b[15];
`endif
                    if (!db_b[1]) m_mode = M_RUN;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("sw_db",     32'(sw_db),     32'(m_db));
        chk("sw_rise",   32'(sw_rise),   32'(m_rise));
        chk("sw_fall",   32'(sw_fall),   32'(m_fall));
        chk("cpu_rst",   32'(cpu_rst),   32'(m_mode == M_RH));
        chk("cpu_ce",    32'(cpu_ce),    32'(m_ce));
        chk("run_state", 32'(run_state), 32'(mode_code(m_mode)));
        chk("disp_mode", 32'(disp_mode), 32'(m_db[3:2]));
        chk("disp_addr", 32'(disp_addr), 32'(m_db[10:4]));
        chk("heartbeat", 32'(heartbeat), 32'(m_hb));
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    int   n_ce;
    logic hb0;

    initial begin
        rst = 1'b1;
        raw = 16'h0000;
        m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
        for (int j = 0; j < DEB; j++) m_win[j] = '0;
        m_mode = M_RH; m_hold = HOLD; m_phase = 0; m_ce = 1'b0; m_hb = 1'b0;

        // 1: reset, hold release, tick cadence
        cyc(2);
        chk("rst_state", 32'(run_state), 32'h0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
        rst = 1'b0;
        cyc(2);
        chk("hold_state", 32'(run_state), 32'h0);
        cyc(1);
        chk("run_entry", 32'(run_state), 32'h1);
        chk("run_cpu_rst", 32'(cpu_rst), 32'h0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < TICK - 1; k++) begin
                cyc(1);
                chk("tick_quiet", 32'(cpu_ce), 32'h0);
            end
            cyc(1);
            chk("tick_ce", 32'(cpu_ce), 32'h1);
        end

        // 2: glitch rejected, stable change accepted
        raw[5] = 1'b1;
        cyc(3);
        raw[5] = 1'b0;
        cyc(8);
        chk("glitch_db", 32'(sw_db[5]), 32'h0);
        raw[5] = 1'b1;
        cyc(5);
        chk("deb_wait", 32'(sw_db[5]), 32'h0);
        cyc(1);
        chk("deb_level", 32'(sw_db[5]), 32'h1);
        chk("deb_rise", 32'(sw_rise[5]), 32'h1);
        cyc(1);
        chk("deb_rise_end", 32'(sw_rise[5]), 32'h0);

        // 3: pause with tick held at 7, resume
        for (int k = 0; k < 2 * TICK && m_phase != 0; k++) cyc(1);
        chk("wait_phase0", 32'(m_phase), 32'h0);
        raw[1] = 1'b1;
        cyc(7);
        chk("pause_entry", 32'(run_state), 32'h2);
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            chk("pause_no_ce", 32'(cpu_ce), 32'h0);
        end
        raw[1] = 1'b0;
        cyc(7);
        chk("resume", 32'(run_state), 32'h1);
        cyc(2);
        chk("resume_quiet", 32'(cpu_ce), 32'h0);
        cyc(1);
        chk("resume_ce", 32'(cpu_ce), 32'h1);

        // 4: step switch in PAUSE and in RUN
        raw[1] = 1'b1;
        cyc(7);
        hb0  = heartbeat;
        raw[15] = 1'b1;
        n_ce = 0;
        for (int k = 0; k < 12; k++) begin cyc(1); n_ce += int'(cpu_ce); end
        cyc(1);
`ifdef BOARD_INPUT_STEP_EN
        chk("step_count", 32'(n_ce), 32'h1);
        chk("step_hb", 32'(heartbeat), 32'(~hb0));
`else
        chk("step_count", 32'(n_ce), 32'h0);
        chk("step_hb", 32'(heartbeat), 32'(hb0));
`endif
        raw[15] = 1'b0;
        cyc(7);
        raw[1] = 1'b0;
        cyc(7);
        chk("step_run", 32'(run_state), 32'h1);
        raw[15] = 1'b1;
        n_ce = 0;
        for (int k = 0; k < 2 * TICK; k++) begin cyc(1); n_ce += int'(cpu_ce); end
        chk("run_step_count", 32'(n_ce), 32'h2);

        // 5: reset request mid-RUN
        raw[0] = 1'b1;
        cyc(6);
        chk("rreq_db", 32'(sw_db[0]), 32'h1);
        cyc(1);
        chk("rreq_cpu_rst", 32'(cpu_rst), 32'h1);
        chk("rreq_state", 32'(run_state), 32'h0);
        chk("rreq_hb", 32'(heartbeat), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("rreq_hold", 32'({cpu_rst, cpu_ce}), 32'h2);
        end
        raw[0] = 1'b0;
        cyc(6);
        chk("rrel_db", 32'(sw_db[0]), 32'h0);
        for (int k = 0; k < 2; k++) begin
            cyc(1);
            chk("rrel_hold", 32'(cpu_rst), 32'h1);
        end
        cyc(1);
        chk("rrel_run", 32'({cpu_rst, run_state}), 32'h1);
        for (int k = 0; k < TICK - 1; k++) begin
            cyc(1);
            chk("restart_quiet", 32'(cpu_ce), 32'h0);
        end
        cyc(1);
        chk("restart_ce", 32'(cpu_ce), 32'h1);

        // 6: display fields
        raw[10:2] = 9'b1010101_10;
        cyc(6);
        chk("disp_addr_55", 32'(disp_addr), 32'h55);
        chk("disp_mode_2", 32'(disp_mode), 32'h2);

        // rst mid-operation with switches set
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_db", 32'(sw_db), 32'h0);
        chk("mid_rst_cpu", 32'({cpu_rst, run_state}), 32'h4);
        rst = 1'b0;

        // randomized switch activity, occasional reset pulses
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(7) == 0) raw[$urandom_range(15, 1)] ^= 1'b1;
            if ($urandom_range(39) == 0) raw[0] = ~raw[0];
            rst = ($urandom_range(149) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
